load_store_unit: RTL

Data-memory access stage of the CPU pipeline. Accepts one load or store from execute, drives the data memory bus (`addr`, `mem_width`, `dispatch_read`/`dispatch_write`, `write_data`, `busy`), waits for completion, and returns a sign- or zero-extended load result to writeback. It also detects misaligned accesses and stuck transactions, and keeps load/store counters. Only one transaction is in flight at a time.

---
 rtl/ProcTypes.sv | 9 +
 rtl/mem.sv | 4 +
 rtl/load_extend.sv | 13 +
 rtl/load_store_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/ProcTypes.sv
// ProcTypes: memory function, load/store unit state and alignment helper.
package ProcTypes;
    typedef enum logic [2:0] {Lb, Lh, Lw, Lbu, Lhu, Sb, Sh, Sw} MemFunc;
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RESP} LsuState;

    function automatic logic is_misaligned(input MemFunc f, input logic [1:0] a);
        return ((f inside {Lh, Lhu, Sh}) && a[0]) || ((f inside {Lw, Sw}) && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem.sv
// mem: data memory bus access width encoding.
package mem;
    typedef enum logic [1:0] {BYTE, WORD, DWORD} width;
endpackage

// File: rtl/load_extend.sv
// load_extend: sign/zero extension of raw memory data for each load function.
module load_extend
    import ProcTypes::*;
(
    input  MemFunc      i_func,
    input  logic [31:0] i_raw,
    output logic [31:0] o_ext
);
    assign o_ext = i_func == Lb  ? {{24{i_raw[7]}}, i_raw[7:0]} :
                   i_func == Lbu ? {24'h0, i_raw[7:0]} :
                   i_func == Lh  ? {{16{i_raw[15]}}, i_raw[15:0]} :
                   i_func == Lhu ? {16'h0, i_raw[15:0]} : i_raw;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store stage driving the data memory bus.
module load_store_unit
    import ProcTypes::*;
    import mem::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  MemFunc      req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_dst,
    output logic [31:0] mem_addr,
    output width        mem_width,
    output logic        mem_dispatch_read,
    output logic        mem_dispatch_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_dst,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores
);
    LsuState     r_state, w_state_nxt;
    MemFunc      r_func;
    logic [31:0] r_addr, r_data, r_wait_cnt, w_ext, w_wdata;
    logic [4:0]  r_dst;
    logic        w_store, w_mis, w_issue, w_done, w_timeout;
    width        w_width;

    load_extend u_ext (.i_func(r_func), .i_raw(mem_read_data), .o_ext(w_ext));

    assign req_ready  = r_state == IDLE;
    assign resp_valid = r_state == RESP;

    always_comb begin
        w_store   = r_func inside {Sb, Sh, Sw};
        w_mis     = is_misaligned(r_func, r_addr[1:0]);
        w_width   = (r_func inside {Lb, Lbu, Sb}) ? BYTE : (r_func inside {Lh, Lhu, Sh}) ? WORD : DWORD;
        w_wdata   = w_width == BYTE ? {24'h0, r_data[7:0]} : w_width == WORD ? {16'h0, r_data[15:0]} : r_data;
        w_issue   = r_state == ISSUE && !w_mis && !mem_busy;
        w_done    = r_state == WAIT && !mem_busy;
        // completion has priority over a timeout in the same cycle
        w_timeout = r_state == WAIT && mem_busy && TIMEOUT_CYCLES != 0 && r_wait_cnt + 32'd1 >= TIMEOUT_CYCLES;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = req_valid ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = w_mis ? RESP : mem_busy ? ISSUE : SETTLE;
            SETTLE:  w_state_nxt = WAIT;
            WAIT:    w_state_nxt = (w_done || w_timeout) ? RESP : WAIT;
            RESP:    w_state_nxt = resp_ready ? IDLE : RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_func             <= Lb;
            r_addr             <= '0;
            r_data             <= '0;
            r_dst              <= '0;
            r_wait_cnt         <= '0;
            mem_addr           <= '0;
            mem_width          <= BYTE;
            mem_dispatch_read  <= 1'b0;
            mem_dispatch_write <= 1'b0;
            mem_write_data     <= '0;
            resp_dst           <= '0;
            resp_data          <= '0;
            resp_err           <= 1'b0;
            perf_loads         <= '0;
            perf_stores        <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_func <= req_func;
                r_addr <= req_addr;
                r_data <= req_data;
                r_dst  <= req_dst;
            end
            mem_dispatch_read  <= w_issue && !w_store;
            mem_dispatch_write <= w_issue && w_store;
            if (w_issue) begin
                mem_addr       <= r_addr;
                mem_width      <= w_width;
                mem_write_data <= w_wdata;
            end
            r_wait_cnt <= r_state == WAIT ? r_wait_cnt + 32'd1 : '0;
            if ((r_state == ISSUE && w_mis) || w_timeout) begin
                resp_err  <= 1'b1;
                resp_data <= '0;
                resp_dst  <= '0;
            end
            if (w_done) begin
                resp_err  <= 1'b0;
                resp_data <= w_store ? '0 : w_ext;
                resp_dst  <= w_store ? '0 : r_dst;
                if (w_store) perf_stores <= perf_stores + 32'd1;
                else perf_loads <= perf_loads + 32'd1;
            end
        end
    end
endmodule
